// File: rtl/subtractor_pkg.sv
// Shared types and defaults for the digit-serial subtractor.
package subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DIGIT = 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/subtractor_serial_sub_digit.sv
// Combinational DIGIT-wide slice subtractor: d = x - y - bin, bout = borrow-out.
module sub_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] w_diff;

  // One extra bit catches the borrow as the wrap of a negative difference.
  assign w_diff = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
  assign d      = w_diff[DIGIT-1:0];
  assign bout   = w_diff[DIGIT];

endmodule

// File: rtl/subtractor_serial.sv
// Digit-serial subtractor, LSB slice first, N = WIDTH/DIGIT cycles per operation.
// Define SUBTRACTOR_SERIAL_ADD_EN to add the op port (op=1 selects a+b).
module subtractor_serial
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUBTRACTOR_SERIAL_ADD_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(N);

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("subtractor_serial: WIDTH must be a multiple of DIGIT");
  end

  state_e            r_state;
  state_e            w_state_d;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic              r_chain;
  logic [CntW-1:0]   r_cnt;

  logic              w_accept;
  logic              w_op;
  logic [DIGIT-1:0]  w_y;
  logic              w_bin;
  logic [DIGIT-1:0]  w_d;
  logic              w_bout;
  logic              w_chain_d;
  logic [WIDTH-1:0]  w_acc_d;

  // ---------------------------------------------------------------------------
  // Optional add mode
  // ---------------------------------------------------------------------------
`ifdef SUBTRACTOR_SERIAL_ADD_EN
  logic r_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= 1'b0;
    end else if (w_accept) begin
      r_op <= op;
    end
  end

  assign w_op = r_op;
`else
  assign w_op = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  assign w_accept = start && (r_state != StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) w_state_d = StRun;
      end
      StRun: begin
        busy = 1'b1;
        if (r_cnt == CntW'(1)) w_state_d = StDone;
      end
      StDone: begin
        done      = 1'b1;
        w_state_d = start ? StRun : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Add reuses the subtractor: x + y + c == x - ~y - ~c, with carry == ~borrow.
  assign w_y       = w_op ? ~r_b[DIGIT-1:0] : r_b[DIGIT-1:0];
  assign w_bin     = w_op ? ~r_chain : r_chain;
  assign w_chain_d = w_op ? ~w_bout : w_bout;

  sub_digit #(
    .DIGIT (DIGIT)
  ) u_sub_digit (
    .x    (r_a[DIGIT-1:0]),
    .y    (w_y),
    .bin  (w_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  // Slice results enter at the top so the first (LSB) slice ends at bit 0.
  if (DIGIT < WIDTH) begin : g_shift
    assign w_acc_d = {w_d, r_acc[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign w_acc_d = w_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_chain <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_acc   <= '0;
      r_chain <= 1'b0;
      r_cnt   <= CntLoad;
    end else if (r_state == StRun) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_d;
      r_chain <= w_chain_d;
      r_cnt   <= r_cnt - CntW'(1);
    end
  end

  assign s = {r_chain, r_acc};

endmodule
